// File: rtl/np_frame_builder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// np_frame_builder
//
// Double-buffered 16-pixel GRB frame store in front of a NeoPixel serial
// controller. The host edits a shadow bank at any time. A commit, or the
// periodic auto-refresh, hands a frame to the controller through a
// ready/go handshake. The frame bank that drives the controller changes
// only while it is idle, so the wire never sees a half-updated frame.
//
// Ports
//   CLOCK_50    in   1    sole clock, rising edge
//   reset       in   1    asynchronous, active-high
//   wr_en       in   1    write wr_color into shadow[wr_addr]
//   wr_addr     in   4    pixel index 0..15
//   wr_color    in   24   GRB value, bit 23 sent first
//   fill_en     in   1    write fill_color into all 16 shadow pixels
//   fill_color  in   24   GRB fill value
//   commit      in   1    request copy shadow -> frame and transmit
//   np_ready    in   1    controller can accept np_go
//   frame_data  out  384  active frame, pixel k at [383-24k -: 24]
//   np_go       out  1    one-cycle start pulse to the controller
//   busy        out  1    a frame is latched or being transmitted
// -----------------------------------------------------------------------------
module np_frame_builder #(
   parameter int unsigned REFRESH_CYCLES = 1000000
) (
   input  logic         CLOCK_50,
   input  logic         reset,
   input  logic         wr_en,
   input  logic [3:0]   wr_addr,
   input  logic [23:0]  wr_color,
   input  logic         fill_en,
   input  logic [23:0]  fill_color,
   input  logic         commit,
   input  logic         np_ready,
   output logic [383:0] frame_data,
   output logic         np_go,
   output logic         busy
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RDY,
      LATCH,
      GO,
      WAIT_LOW,
      WAIT_DONE
   } state_t;

   localparam logic [23:0] REFRESH_LAST = 24'(REFRESH_CYCLES - 1);

   state_t      state_q, state_d;
   logic [23:0] shadow_q [16];
   logic [23:0] shadow_d [16];
   logic [23:0] frame_q  [16];
   logic [23:0] frame_d  [16];
   logic        pending_q, pending_d;
   logic [23:0] refresh_q, refresh_d;
   logic [1:0]  low_cnt_q, low_cnt_d;
   logic        refresh_expired;

   assign refresh_expired = (refresh_q == REFRESH_LAST);

   // Handshake FSM: next state and the two status outputs.
   always_comb begin
      // NOTE: every output of this block gets a default before the case, so
      // no path through it can leave a value unassigned and infer a latch.
      state_d   = state_q;
      low_cnt_d = low_cnt_q;
      np_go     = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            // commit is looked at directly as well as through pending, so a
            // request leaves IDLE on the same edge that records it.
            if (pending_q || commit || refresh_expired) begin
               state_d = WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            if (np_ready) begin
               state_d = LATCH;
            end
         end
         LATCH: begin
            busy    = 1'b1;
            state_d = GO;
         end
         GO: begin
            busy = 1'b1;
            // Hold the pulse back if the controller dropped ready between
            // WAIT_RDY and here; go must never meet a not-ready controller.
            if (np_ready) begin
               np_go     = 1'b1;
               low_cnt_d = 2'd0;
               state_d   = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            busy = 1'b1;
            // A controller that never visibly drops ready is given 4 cycles.
            if (!np_ready || low_cnt_q == 2'd3) begin
               state_d = WAIT_DONE;
            end else begin
               low_cnt_d = low_cnt_q + 2'd1;
            end
         end
         WAIT_DONE: begin
            busy = 1'b1;
            if (np_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: shadow edits, commit bookkeeping, refresh timer, frame copy.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         shadow_d[i] = fill_en ? fill_color : shadow_q[i];
         // A single-pixel write wins over a fill in the same cycle.
         if (wr_en && wr_addr == 4'(i)) begin
            shadow_d[i] = wr_color;
         end
      end

      // A commit in LATCH arrives after the copy was taken from shadow_q, so
      // it must survive the clear and cause one more transmission.
      pending_d = pending_q;
      if (state_q == LATCH) begin
         pending_d = 1'b0;
      end
      if (commit) begin
         pending_d = 1'b1;
      end

      // Counts only while idle or waiting; saturates so an expiry is not
      // lost while the controller is not ready. Restarts on the way to GO.
      refresh_d = refresh_q;
      if ((state_q == IDLE || state_q == WAIT_RDY) && !refresh_expired) begin
         refresh_d = refresh_q + 24'd1;
      end
      if (state_q == LATCH) begin
         refresh_d = 24'd0;
      end

      // A pure refresh retransmits the existing frame unchanged.
      frame_d = frame_q;
      if (state_q == LATCH && pending_q) begin
         frame_d = shadow_q;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= 1'b0;
         refresh_q <= 24'd0;
         low_cnt_q <= 2'd0;
         // NOTE: both banks are plain flops rather than RAM, so they can and
         // must be cleared by reset to give an all-dark frame.
         for (int i = 0; i < 16; i++) begin
            shadow_q[i] <= 24'h000000;
            frame_q[i]  <= 24'h000000;
         end
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values,
         // independent of statement order.
         state_q   <= state_d;
         pending_q <= pending_d;
         refresh_q <= refresh_d;
         low_cnt_q <= low_cnt_d;
         shadow_q  <= shadow_d;
         frame_q   <= frame_d;
      end
   end

   always_comb begin
      frame_data = '0;
      for (int k = 0; k < 16; k++) begin
         frame_data[383 - 24*k -: 24] = frame_q[k];
      end
   end

endmodule

// File: tb/tb_np_frame_builder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_np_frame_builder
//
// Directed bench for np_frame_builder. Stimulus pushes the frame it expects
// each np_go to carry into a queue; an independent monitor pops one entry per
// np_go and compares. A small controller model drops np_ready for a few
// cycles after each go, and the stimulus can hold it low.
// -----------------------------------------------------------------------------
module tb_np_frame_builder;

   localparam int unsigned R        = 40;  // refresh period used here
   localparam int          CTL_BUSY = 3;   // cycles ready stays low after go

   logic         clk = 1'b0;
   logic         reset;
   logic         wr_en, fill_en, commit, np_ready;
   logic [3:0]   wr_addr;
   logic [23:0]  wr_color, fill_color;
   logic [383:0] frame_data;
   logic         np_go, busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_go    = 0;

   logic [23:0]  m_shadow [16];
   logic [383:0] exp_q [$];
   bit           ctl_hold = 1'b0;

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   np_frame_builder #(.REFRESH_CYCLES(R)) dut (
      .CLOCK_50  (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_color  (wr_color),
      .fill_en   (fill_en),
      .fill_color(fill_color),
      .commit    (commit),
      .np_ready  (np_ready),
      .frame_data(frame_data),
      .np_go     (np_go),
      .busy      (busy)
   );

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   task automatic check_frame(input string name, input logic [383:0] got, input logic [383:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   function automatic logic [383:0] pack_model();
      logic [383:0] v;
      for (int k = 0; k < 16; k++) v[383 - 24*k -: 24] = m_shadow[k];
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_px(input logic [3:0] a, input logic [23:0] c);
      wr_en = 1'b1; wr_addr = a; wr_color = c;
      step();
      wr_en = 1'b0;
      m_shadow[a] = c;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      step();
      commit = 1'b0;
   endtask

   task automatic set_hold(input bit v);
      @(negedge clk);
      ctl_hold = v;
      step();
   endtask

   task automatic wait_go(input string name, input int max_cyc, output int at_cyc);
      bit found = 1'b0;
      at_cyc = -1;
      for (int c = 0; c < max_cyc && !found; c++) begin
         @(negedge clk);
         if (np_go) begin
            found  = 1'b1;
            at_cyc = cyc;
         end
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL %s_timeout: got no np_go within %0d cycles, required one", name, max_cyc);
      end
      step();
   endtask

   // Controller model: sole driver of np_ready.
   initial begin
      bit go_s;
      int cnt = 0;
      np_ready = 1'b1;
      forever begin
         @(negedge clk);
         go_s = np_go;
         @(posedge clk);
         #1;
         if (go_s) cnt = CTL_BUSY;
         else if (cnt > 0) cnt--;
         np_ready = !ctl_hold && cnt == 0;
      end
   end

   // Monitor: one scoreboard entry per np_go.
   initial begin
      bit prev_go = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset && np_go) begin
            n_go++;
            check("go_needs_ready", int'(np_ready), 1);
            check("go_busy", int'(busy), 1);
            if (prev_go) begin
               n_tests++; n_fail++;
               $display("FAIL go_width: got np_go high two cycles at cycle %0d, required one", cyc);
            end
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_go: got np_go at cycle %0d, required no pulse", cyc);
            end else begin
               check_frame("go_frame", frame_data, exp_q.pop_front());
            end
         end
         prev_go = np_go;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no end of test by %0t, required completion", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, g0, g1, g2, go_before;
      bit bad;
      reset = 1'b1; wr_en = 1'b0; fill_en = 1'b0; commit = 1'b0;
      wr_addr = '0; wr_color = '0; fill_color = '0;
      for (int i = 0; i < 16; i++) m_shadow[i] = 24'h000000;

      // Reset state.
      #35;
      check("rst_busy", int'(busy), 0);
      check("rst_go", int'(np_go), 0);
      check_frame("rst_frame", frame_data, '0);
      step();
      reset = 1'b0;
      repeat (2) step();

      // Two corner pixels, commit, go exactly 3 cycles later.
      write_px(4'd0, 24'h00FF00);
      write_px(4'd15, 24'h0000FF);
      exp_q.push_back(pack_model());
      commit = 1'b1;
      lat = -1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (np_go && lat < 0) lat = c;
         step();
         commit = 1'b0;
      end
      check("t035_latency", lat, 3);
      check("t035_px0", int'(frame_data[383:360]), 32'h00FF00);
      check("t035_px15", int'(frame_data[23:0]), 32'h0000FF);
      repeat (8) step();

      // Fill and single write on the same cycle.
      fill_en = 1'b1; fill_color = 24'h101010;
      wr_en = 1'b1; wr_addr = 4'd5; wr_color = 24'hFF0000;
      step();
      fill_en = 1'b0; wr_en = 1'b0;
      for (int i = 0; i < 16; i++) m_shadow[i] = 24'h101010;
      m_shadow[5] = 24'hFF0000;
      exp_q.push_back(pack_model());
      do_commit();
      wait_go("t036", 20, g0);
      check("t036_px4", int'(frame_data[383 - 24*4 -: 24]), 32'h101010);
      check("t036_px5", int'(frame_data[383 - 24*5 -: 24]), 32'hFF0000);

      // Auto-refresh with no commit: same frame, fixed period
      // (R counting cycles + LATCH/GO lead + controller turnaround).
      exp_q.push_back(pack_model());
      exp_q.push_back(pack_model());
      wait_go("t039_a", R + 20, g1);
      check("t039_gap1", g1 - g0, R + CTL_BUSY + 4);
      wait_go("t039_b", R + 20, g2);
      check("t039_gap2", g2 - g1, R + CTL_BUSY + 4);
      repeat (8) step();

      // Commit while the controller is not ready for 100 cycles.
      set_hold(1'b1);
      write_px(4'd7, 24'h123456);
      exp_q.push_back(pack_model());
      do_commit();
      bad = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (np_go || busy) bad = 1'b1;
      end
      check("t037_quiet_while_not_ready", int'(bad), 0);
      ctl_hold = 1'b0;
      lat = -1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (np_go && lat < 0) lat = c;
      end
      check("t037_go_within_2", int'(lat >= 0 && lat <= 2), 1);
      repeat (8) step();

      // Three commits during WAIT_DONE -> exactly one more go, last contents.
      write_px(4'd2, 24'hAAAAAA);
      exp_q.push_back(pack_model());
      do_commit();
      wait_go("t038_first", 20, g0);
      set_hold(1'b1);
      write_px(4'd3, 24'h111111);
      do_commit();
      write_px(4'd3, 24'h222222);
      do_commit();
      write_px(4'd4, 24'h333333);
      do_commit();
      @(negedge clk);
      check("t038_busy_in_wait_done", int'(busy), 1);
      exp_q.push_back(pack_model());
      go_before = n_go;
      set_hold(1'b0);
      wait_go("t038_extra", 20, g1);
      repeat (30) step();
      check("t038_one_extra_go", n_go - go_before, 1);

      // Reset in WAIT_DONE with a commit pending.
      write_px(4'd9, 24'h0F0F0F);
      exp_q.push_back(pack_model());
      do_commit();
      wait_go("t040_first", 20, g0);
      set_hold(1'b1);
      write_px(4'd10, 24'h0A0A0A);
      do_commit();
      #3;
      reset = 1'b1;
      ctl_hold = 1'b0;
      #1;
      check("t040_busy", int'(busy), 0);
      check("t040_go", int'(np_go), 0);
      check_frame("t040_frame", frame_data, '0);
      for (int i = 0; i < 16; i++) m_shadow[i] = 24'h000000;
      step();
      reset = 1'b0;
      go_before = n_go;
      repeat (R) @(negedge clk);
      check("t040_no_go_after_release", n_go - go_before, 0);
      exp_q.push_back(pack_model());
      wait_go("t040_refresh", 20, g1);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
